sp_align_ctrl: RTL

//  Byte-alignment and link-state controller for the PHY RX serial-to-parallel path.

---
 rtl/sp_align_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sp_align_ctrl.sv
// sp_align_ctrl: RX byte aligner and link-state controller.
// Hunts for COMMA in the serial stream, locks, then emits aligned bytes.
module sp_align_ctrl #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         N_LOCK     = 4,
  parameter int         LOSS_BYTES = 64
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  input  logic       resync,
  output logic [7:0] sp_out,
  output logic       valid_out_sp,
  output logic       byte_strobe,
  output logic       active
);

  localparam int CW = $clog2(N_LOCK + 1);
  localparam int LW = $clog2(LOSS_BYTES + 1);
  localparam logic [CW-1:0] NL = CW'(N_LOCK);
  localparam logic [LW-1:0] NB = LW'(LOSS_BYTES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [7:0]      shreg;
  logic [2:0]      bit_cnt;
  logic [2:0]      bit_cnt_d;
  logic [CW-1:0]   comma_cnt;
  logic [CW-1:0]   comma_d;
  logic [LW-1:0]   loss_cnt;
  logic [LW-1:0]   loss_d;
  logic [7:0]      sp_d;
  logic            valid_d;
  logic            strobe_d;
  logic            active_d;

  logic [7:0]      nxt;
  logic            boundary;
  logic            is_comma;
  logic            lock_hit;
  logic            loss_hit;

  assign nxt      = {shreg[6:0], data_in};
  assign boundary = (bit_cnt == 3'd7);
  assign is_comma = (nxt == COMMA);
  assign lock_hit = (comma_cnt + CW'(1)) == NL;
  assign loss_hit = ((loss_cnt + LW'(1)) == NB)
                    && !is_comma;

  // State register
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) state_q <= SEARCH;
    else       state_q <= state_d;
  end

  // Next-state: resync wins, else per-state lock/loss decisions
  always_comb begin
    state_d = state_q;
    if (resync) begin
      state_d = SEARCH;
    end else begin
      unique case (state_q)
        SEARCH: begin
          if (is_comma)
            state_d = (N_LOCK == 1) ? ACTIVE : ALIGN;
        end
        ALIGN: begin
          if (boundary) begin
            if (!is_comma)     state_d = SEARCH;
            else if (lock_hit) state_d = ACTIVE;
          end
        end
        ACTIVE: begin
          if (boundary && loss_hit)
            state_d = SEARCH;
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // Output/datapath next values; active lags the loss exit by one edge
  always_comb begin
    bit_cnt_d = bit_cnt + 3'd1;
    comma_d   = comma_cnt;
    loss_d    = loss_cnt;
    sp_d      = sp_out;
    valid_d   = valid_out_sp;
    strobe_d  = 1'b0;
    active_d  = active;
    if (resync) begin
      comma_d  = '0;
      loss_d   = '0;
      valid_d  = 1'b0;
      active_d = 1'b0;
    end else begin
      unique case (state_q)
        SEARCH: begin
          valid_d  = 1'b0;
          active_d = 1'b0;
          loss_d   = '0;
          comma_d  = '0;
          if (is_comma) begin
            bit_cnt_d = 3'd0;
            comma_d   = CW'(1);
            if (N_LOCK == 1) active_d = 1'b1;
          end
        end
        ALIGN: begin
          valid_d  = 1'b0;
          active_d = 1'b0;
          if (boundary) begin
            if (is_comma) begin
              comma_d = comma_cnt + CW'(1);
              if (lock_hit) begin
                active_d = 1'b1;
                loss_d   = '0;
              end
            end else begin
              comma_d = '0;
            end
          end
        end
        ACTIVE: begin
          if (boundary) begin
            sp_d     = nxt;
            strobe_d = 1'b1;
            valid_d  = !is_comma;
            if (is_comma) loss_d = '0;
            else          loss_d = loss_cnt + LW'(1);
            if (loss_hit) begin
              loss_d  = '0;
              comma_d = '0;
            end
          end
        end
        default: begin
          valid_d  = 1'b0;
          active_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output registers; shreg shifts every edge
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      comma_cnt    <= '0;
      loss_cnt     <= '0;
      sp_out       <= '0;
      valid_out_sp <= 1'b0;
      byte_strobe  <= 1'b0;
      active       <= 1'b0;
    end else begin
      shreg        <= nxt;
      bit_cnt      <= bit_cnt_d;
      comma_cnt    <= comma_d;
      loss_cnt     <= loss_d;
      sp_out       <= sp_d;
      valid_out_sp <= valid_d;
      byte_strobe  <= strobe_d;
      active       <= active_d;
    end
  end

endmodule
